weight_load_ctrl: RTL and testbench

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_sched_pkg.sv | 18 +
 rtl/wsched_bank_tracker.sv | 45 ++++
 rtl/weight_load_ctrl.sv | 94 +++++++++
 tb/tb_weight_load_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sched_pkg.sv
// rtl/weight_sched_pkg.sv - shared constants and FSM encoding for the weight load scheduler
package weight_sched_pkg;

  localparam int BANK_BEATS = 2048;
  localparam int BURST_MAX  = 256;
  localparam int LEN_W      = 13;
  localparam int REM_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_BUSY  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/wsched_bank_tracker.sv
// rtl/wsched_bank_tracker.sv - ping/pong bank fill level, write pointer and full flags
module wsched_bank_tracker #(
  parameter int BANK_BEATS = 2048,
  parameter int FILL_W     = 12,
  parameter int LEN_W      = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              burst_done,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        bank_release,
  output logic [FILL_W-1:0] fill,
  output logic              wr_bank,
  output logic [1:0]        bank_full
);

  logic [FILL_W:0] fill_sum;
  logic            bank_wrap;
  logic [1:0]      set_mask;

  always_comb begin
    fill_sum  = {1'b0, fill} + (FILL_W+1)'(len);
    bank_wrap = burst_done && (fill_sum == (FILL_W+1)'(BANK_BEATS));
    set_mask  = 2'b00;
    if (bank_wrap) set_mask[wr_bank] = 1'b1;
  end

  // Release only clears bits already set; a simultaneous set on the same bank wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill      <= '0;
      wr_bank   <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~bank_release) | set_mask;
      if (bank_wrap) begin
        fill    <= '0;
        wr_bank <= ~wr_bank;
      end else if (burst_done) begin
        fill    <= fill_sum[FILL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - splits weight load jobs into bank-aligned weight-port bursts
module weight_load_ctrl #(
  parameter int BANK_BEATS = weight_sched_pkg::BANK_BEATS,
  parameter int BURST_MAX  = weight_sched_pkg::BURST_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  input  logic [15:0] job_beats,
  output logic        job_ready,
  output logic        job_done,
  input  logic        src_rdy,
  output logic        wp_start,
  output logic [12:0] wp_tran_time,
  input  logic        wp_done,
  output logic [1:0]  bank_full,
  input  logic [1:0]  bank_release,
  output logic        wr_bank
);
  import weight_sched_pkg::*;

  localparam int FILL_W = $clog2(BANK_BEATS + 1);

  state_t             state, state_nxt;
  logic [REM_W-1:0]   remaining;
  logic [FILL_W-1:0]  fill;
  logic [LEN_W-1:0]   len_calc;
  logic [16:0]        room;
  logic [16:0]        lim;
  logic               burst_done;
  logic               last_burst;

  always_comb begin
    room = 17'(BANK_BEATS) - 17'(fill);
    lim  = 17'(BURST_MAX);
    if (17'(remaining) < lim) lim = 17'(remaining);
    if (room < lim) lim = room;
    len_calc   = lim[LEN_W-1:0];
    burst_done = (state == ST_BUSY) && wp_done;
    last_burst = (remaining == REM_W'(wp_tran_time));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (job_valid) state_nxt = ST_CALC;
      ST_CALC:  state_nxt = ST_WAIT;
      ST_WAIT:  if (!bank_full[wr_bank] && src_rdy) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_BUSY;
      ST_BUSY:  if (wp_done) state_nxt = last_burst ? ST_DONE : ST_CALC;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    job_ready = (state == ST_IDLE);
    wp_start  = (state == ST_ISSUE);
    job_done  = (state == ST_DONE);
  end

  // Burst length is frozen in CALC so it stays stable through the weight-port handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining    <= '0;
      wp_tran_time <= '0;
    end else begin
      if (state == ST_IDLE && job_valid) remaining <= job_beats;
      if (state == ST_CALC) wp_tran_time <= len_calc;
      if (burst_done) remaining <= remaining - REM_W'(wp_tran_time);
    end
  end

  wsched_bank_tracker #(
    .BANK_BEATS (BANK_BEATS),
    .FILL_W     (FILL_W),
    .LEN_W      (LEN_W)
  ) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .burst_done   (burst_done),
    .len          (wp_tran_time),
    .bank_release (bank_release),
    .fill         (fill),
    .wr_bank      (wr_bank),
    .bank_full    (bank_full)
  );

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - self-checking bench for weight_load_ctrl
module tb_weight_load_ctrl;

  localparam int BANK = 2048;
  localparam int BMAX = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic [15:0] job_beats = '0;
  logic        job_ready;
  logic        job_done;
  logic        src_rdy = 1'b1;
  logic        wp_start;
  logic [12:0] wp_tran_time;
  logic        wp_done = 1'b0;
  logic [1:0]  bank_full;
  logic [1:0]  bank_release = 2'b00;
  logic        wr_bank;

  int n_checks = 0;
  int n_pass = 0;

  int       fill_m = 0;
  int       wrb_m = 0;
  bit [1:0] full_m = 2'b00;
  int       lens_q[$];

  weight_load_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_beats    (job_beats),
    .job_ready    (job_ready),
    .job_done     (job_done),
    .src_rdy      (src_rdy),
    .wp_start     (wp_start),
    .wp_tran_time (wp_tran_time),
    .wp_done      (wp_done),
    .bank_full    (bank_full),
    .bank_release (bank_release),
    .wr_bank      (wr_bank)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Drives one job through a weight-port responder and checks every burst against the model.
  task automatic run_job(input int beats, input int src_low, input bit rel_on_fill);
    int rem, len, lat;
    bit first, seen;
    n_checks++;
    if (job_ready !== 1'b1) $display("FAIL job_ready_before_accept: got %0b expected 1", job_ready);
    else n_pass++;
    lens_q.delete();
    if (src_low > 0) src_rdy = 1'b0;
    job_valid = 1'b1;
    job_beats = 16'(beats);
    tick();
    job_valid = 1'b0;
    job_beats = 16'($urandom);
    rem = beats;
    first = 1'b1;
    while (rem > 0) begin
      len = BMAX;
      if (rem < len) len = rem;
      if (BANK - fill_m < len) len = BANK - fill_m;
      if (full_m[wrb_m]) begin
        seen = 1'b0;
        repeat (10) begin
          if (wp_start) seen = 1'b1;
          tick();
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL stall_no_start: got start %0b expected 0", seen);
        else n_pass++;
        bank_release[wrb_m] = 1'b1;
        tick();
        bank_release = 2'b00;
        full_m[wrb_m] = 1'b0;
        n_checks++;
        if (wp_start !== 1'b0) $display("FAIL release_early_start: got %0b expected 0", wp_start);
        else n_pass++;
        tick();
        n_checks++;
        if (wp_start !== 1'b1) $display("FAIL release_start: got %0b expected 1", wp_start);
        else n_pass++;
      end else if (first && src_low > 0) begin
        seen = 1'b0;
        for (int k = 0; k < src_low; k++) begin
          if (wp_start) seen = 1'b1;
          wp_done = (k == 5);
          tick();
        end
        wp_done = 1'b0;
        n_checks++;
        if (seen !== 1'b0) $display("FAIL src_low_no_start: got start %0b expected 0", seen);
        else n_pass++;
        src_rdy = 1'b1;
        tick();
        n_checks++;
        if (wp_start !== 1'b1) $display("FAIL src_rdy_start: got %0b expected 1", wp_start);
        else n_pass++;
      end else begin
        lat = 1;
        while (!wp_start && lat < 20) begin
          tick();
          lat++;
        end
        n_checks++;
        if (lat !== 3) $display("FAIL start_latency: got %0d cycles expected 3", lat);
        else n_pass++;
      end
      n_checks++;
      if (wp_tran_time !== 13'(len)) $display("FAIL tran_time: got %0d expected %0d", wp_tran_time, len);
      else n_pass++;
      lens_q.push_back(int'(wp_tran_time));
      repeat ($urandom_range(1, 4)) tick();
      n_checks++;
      if (wp_tran_time !== 13'(len)) $display("FAIL tran_time_hold: got %0d expected %0d", wp_tran_time, len);
      else n_pass++;
      wp_done = 1'b1;
      if (rel_on_fill && fill_m + len == BANK) bank_release[wrb_m] = 1'b1;
      tick();
      wp_done = 1'b0;
      bank_release = 2'b00;
      fill_m += len;
      rem -= len;
      if (fill_m == BANK) begin
        full_m[wrb_m] = 1'b1;
        wrb_m ^= 1;
        fill_m = 0;
      end
      n_checks++;
      if (bank_full !== full_m) $display("FAIL bank_full: got %b expected %b", bank_full, full_m);
      else n_pass++;
      n_checks++;
      if (wr_bank !== 1'(wrb_m)) $display("FAIL wr_bank: got %0b expected %0d", wr_bank, wrb_m);
      else n_pass++;
      n_checks++;
      if (int'(dut.u_bank.fill) !== fill_m) $display("FAIL fill: got %0d expected %0d", dut.u_bank.fill, fill_m);
      else n_pass++;
      n_checks++;
      if (job_done !== (rem == 0)) $display("FAIL job_done_pulse: got %0b expected %0b", job_done, (rem == 0));
      else n_pass++;
      first = 1'b0;
    end
    tick();
    n_checks++;
    if (job_done !== 1'b0 || job_ready !== 1'b1)
      $display("FAIL job_end: got done=%0b ready=%0b expected done=0 ready=1", job_done, job_ready);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({wp_start, job_done, bank_full, wr_bank, wp_tran_time} !== 18'd0)
      $display("FAIL reset_outputs: got start=%0b done=%0b full=%b wrb=%0b tt=%0d expected all 0",
               wp_start, job_done, bank_full, wr_bank, wp_tran_time);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (job_ready !== 1'b1) $display("FAIL reset_job_ready: got %0b expected 1", job_ready);
    else n_pass++;
  endtask

  task automatic test_single_job;
    run_job(300, 0, 0);
    n_checks++;
    if (lens_q.size() !== 2 || lens_q[0] !== 256 || lens_q[1] !== 44)
      $display("FAIL single_job_bursts: got n=%0d first=%0d expected 2 bursts 256,44",
               lens_q.size(), (lens_q.size() > 0) ? lens_q[0] : -1);
    else n_pass++;
    n_checks++;
    if (bank_full !== 2'b00 || int'(dut.u_bank.fill) !== 300)
      $display("FAIL single_job_state: got full=%b fill=%0d expected 00 300", bank_full, dut.u_bank.fill);
    else n_pass++;
  endtask

  task automatic test_bank_boundary;
    run_job(1700, 0, 0);
    run_job(100, 0, 0);
    n_checks++;
    if (lens_q.size() !== 2 || lens_q[0] !== 48 || lens_q[1] !== 52)
      $display("FAIL boundary_bursts: got n=%0d first=%0d expected 2 bursts 48,52",
               lens_q.size(), (lens_q.size() > 0) ? lens_q[0] : -1);
    else n_pass++;
    n_checks++;
    if (bank_full !== 2'b01 || wr_bank !== 1'b1 || int'(dut.u_bank.fill) !== 52)
      $display("FAIL boundary_state: got full=%b wrb=%0b fill=%0d expected 01 1 52",
               bank_full, wr_bank, dut.u_bank.fill);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    run_job(1996, 0, 0);
    n_checks++;
    if (bank_full !== 2'b11) $display("FAIL both_full: got %b expected 11", bank_full);
    else n_pass++;
    run_job(16, 0, 0);
  endtask

  task automatic test_release_collision;
    run_job(2 * BANK - fill_m, 0, 1);
    n_checks++;
    if (bank_full !== 2'b11) $display("FAIL collision_set_wins: got %b expected 11", bank_full);
    else n_pass++;
  endtask

  task automatic test_src_rdy;
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
    full_m = 2'b00;
    n_checks++;
    if (bank_full !== 2'b00) $display("FAIL release_both: got %b expected 00", bank_full);
    else n_pass++;
    run_job(40, 12, 0);
  endtask

  task automatic test_reset_mid_burst;
    int w;
    bit seen;
    job_valid = 1'b1;
    job_beats = 16'd100;
    tick();
    job_valid = 1'b0;
    w = 0;
    while (!wp_start && w < 20) begin
      tick();
      w++;
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wp_start, job_done, bank_full, wr_bank, wp_tran_time} !== 18'd0 || job_ready !== 1'b1)
      $display("FAIL mid_reset_outputs: got start=%0b done=%0b full=%b wrb=%0b tt=%0d ready=%0b expected zeros ready=1",
               wp_start, job_done, bank_full, wr_bank, wp_tran_time, job_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    fill_m = 0;
    wrb_m = 0;
    full_m = 2'b00;
    seen = 1'b0;
    repeat (4) begin
      if (job_done) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mid_reset_no_done: got %0b expected 0", seen);
    else n_pass++;
    run_job(16, 0, 0);
    n_checks++;
    if (lens_q.size() !== 1 || lens_q[0] !== 16 || int'(dut.u_bank.fill) !== 16)
      $display("FAIL post_reset_job: got n=%0d fill=%0d expected 1 burst of 16 fill 16",
               lens_q.size(), dut.u_bank.fill);
    else n_pass++;
  endtask

  task automatic test_random_jobs;
    for (int j = 0; j < 5; j++)
      run_job(int'($urandom_range(1, 2500)), 0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_bank_boundary();
    test_backpressure();
    test_release_collision();
    test_src_rdy();
    test_reset_mid_burst();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
